// File: rtl/pattern_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_source_if
//  Description : AXI-stream style pixel bus carried from pattern_source to the
//                VGA pixel input. One beat = one {r,g,b} pixel plus the
//                start-of-frame (tuser) and end-of-line (tlast) sidebands.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    pixel_tvalid  source -> sink  beat valid
//    pixel_tready  sink -> source  sink ready to accept the beat
//    pixel_tdata   source -> sink  pixel, packed {r,g,b}, 3*COLOR_BITS wide
//    pixel_tuser   source -> sink  first pixel of a frame (x=0, y=0)
//    pixel_tlast   source -> sink  last pixel of a line
//  Modports
//    master : pixel source (pattern_source)
//    slave  : pixel sink (vga block or testbench)
// ============================================================================
interface pattern_source_if #(
    parameter int COLOR_BITS = 4
) ();

    logic                      pixel_tvalid;
    logic                      pixel_tready;
    logic [3*COLOR_BITS-1:0]   pixel_tdata;
    logic                      pixel_tuser;
    logic                      pixel_tlast;

    modport master (
        output pixel_tvalid,
        output pixel_tdata,
        output pixel_tuser,
        output pixel_tlast,
        input  pixel_tready
    );

    modport slave (
        input  pixel_tvalid,
        input  pixel_tdata,
        input  pixel_tuser,
        input  pixel_tlast,
        output pixel_tready
    );

endinterface : pattern_source_if
`default_nettype wire

// File: rtl/pattern_source.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_source
//  Description : Parametrised AXI-stream test-pattern generator. Emits exactly
//                H_ACTIVE x V_ACTIVE pixels per frame with start-of-frame
//                (tuser) and end-of-line (tlast) sidebands, choosing one of
//                four patterns (COUNT, BARS, CHECKER, SOLID) per frame and
//                honouring full valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    H_ACTIVE    pixels per line (>= 2)
//    V_ACTIVE    lines per frame (>= 2)
//    COLOR_BITS  bits per colour channel; pixel is 3*COLOR_BITS, {r,g,b}
//    BAR_COUNT   number of vertical colour bars (1..8, <= H_ACTIVE)
//    CHECK_LOG2  checker square edge is 2**CHECK_LOG2 pixels
//  Ports
//    clk          in   system clock
//    reset        in   synchronous active-high reset
//    enable       in   run request, sampled at frame boundaries only
//    mode         in   0=COUNT 1=BARS 2=CHECKER 3=SOLID, sampled at frame start
//    solid_color  in   colour for SOLID, sampled at frame start
//    pix          if   pixel stream, master side (tvalid/tready/tdata/tuser/tlast)
//    frame_done   out  one-cycle pulse after the final beat of a frame is taken
//  Build option
//    PATTERN_SCROLL_EN  when defined, a horizontal offset advances by one
//                       pixel per frame and is applied to BARS and CHECKER.
// ============================================================================
module pattern_source #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COLOR_BITS = 4,
    parameter int BAR_COUNT  = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    enable,
    input  wire logic [1:0]              mode,
    input  wire logic [3*COLOR_BITS-1:0] solid_color,
    pattern_source_if.master             pix,
    output logic                         frame_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int PW    = 3 * COLOR_BITS;
    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_W = H_ACTIVE / BAR_COUNT;
    localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [2:0]    BAR_LAST = 3'(BAR_COUNT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAR_W - 1);

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_BARS    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_SOLID   = 2'd3;

    // Horizontal position used by the BARS/CHECKER patterns (x' = x + offset),
    // together with the bar index and the position inside the current bar.
    // Tracking the bar incrementally avoids a divider on the pixel path.
    typedef struct packed {
        logic [XW-1:0] xp;
        logic [2:0]    idx;
        logic [CW-1:0] cnt;
    } bar_pos_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Advance x' by one pixel, wrapping at the end of the line. The bar index
    // saturates at the last bar so any remainder pixels extend that bar.
    function automatic bar_pos_t bar_step(input bar_pos_t p);
        bar_pos_t n;
        n = p;
        if (p.xp == X_LAST) begin
            n.xp  = '0;
            n.idx = '0;
            n.cnt = '0;
        end else begin
            n.xp = p.xp + 1'b1;
            if (p.idx != BAR_LAST) begin
                if (p.cnt == CNT_LAST) begin
                    n.idx = p.idx + 3'd1;
                    n.cnt = '0;
                end else begin
                    n.cnt = p.cnt + 1'b1;
                end
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    bar_pos_t        pos_q;
    logic [PW-1:0]   count_q;
    logic [1:0]      mode_q;
    logic [PW-1:0]   solid_q;
    logic            tvalid_q;
    logic [PW-1:0]   tdata_q;
    logic            tuser_q;
    logic            tlast_q;
    logic            frame_done_q;

    // Next-beat values
    logic            w_accept;
    logic            w_last_beat;
    logic            w_frame_end;
    logic            w_start;
    logic            w_step;
    logic            w_load;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    bar_pos_t        pos_d;
    logic [1:0]      mode_d;
    logic [PW-1:0]   solid_d;
    logic [PW-1:0]   tdata_d;
    logic            tuser_d;
    logic            tlast_d;
    logic            w_xbit;
    logic            w_ybit;

    // x' at the start of each line in the current frame, and at the start of
    // the frame that follows a frame boundary.
    bar_pos_t        w_line_start;
    bar_pos_t        w_next_off;

    // ------------------------------------------------------------------------
    // Optional per-frame horizontal scroll
    // ------------------------------------------------------------------------
`ifdef PATTERN_SCROLL_EN
    bar_pos_t off_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            off_q <= '0;
        end else if (w_frame_end) begin
            off_q <= bar_step(off_q);
        end
    end

    assign w_line_start = off_q;
    // A back-to-back frame is loaded on the same edge the offset advances,
    // so it must see the advanced value directly.
    assign w_next_off   = bar_step(off_q);
`else
    assign w_line_start = '0;
    assign w_next_off   = '0;
`endif

    // ------------------------------------------------------------------------
    // Next-beat coordinates
    // ------------------------------------------------------------------------
    always_comb begin
        w_accept    = tvalid_q & pix.pixel_tready;
        w_last_beat = (x_q == X_LAST) && (y_q == Y_LAST);
        w_frame_end = (state_q == S_RUN) && w_accept && w_last_beat;
        w_start     = enable && ((state_q == S_IDLE) || w_frame_end);
        w_step      = (state_q == S_RUN) && w_accept && !w_last_beat;
        w_load      = w_start || w_step;

        x_d     = x_q;
        y_d     = y_q;
        pos_d   = pos_q;
        mode_d  = mode_q;
        solid_d = solid_q;

        if (w_start) begin
            x_d     = '0;
            y_d     = '0;
            pos_d   = (state_q == S_IDLE) ? w_line_start : w_next_off;
            mode_d  = mode;
            solid_d = solid_color;
        end else if (x_q == X_LAST) begin
            x_d   = '0;
            y_d   = y_q + 1'b1;
            pos_d = w_line_start;
        end else begin
            x_d   = x_q + 1'b1;
            pos_d = bar_step(pos_q);
        end
    end

    // Checker bits; a bit beyond the coordinate width reads as 0.
    if (CHECK_LOG2 < XW) begin : g_chk_x
        assign w_xbit = pos_d.xp[CHECK_LOG2];
    end else begin : g_chk_x_zero
        assign w_xbit = 1'b0;
    end

    if (CHECK_LOG2 < YW) begin : g_chk_y
        assign w_ybit = y_d[CHECK_LOG2];
    end else begin : g_chk_y_zero
        assign w_ybit = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Next-beat pixel and sidebands
    // ------------------------------------------------------------------------
    always_comb begin
        tdata_d = '0;
        unique case (mode_d)
            MODE_COUNT:   tdata_d = count_q;
            MODE_BARS:    tdata_d = {{COLOR_BITS{pos_d.idx[2]}},
                                     {COLOR_BITS{pos_d.idx[1]}},
                                     {COLOR_BITS{pos_d.idx[0]}}};
            MODE_CHECKER: tdata_d = {PW{w_xbit ^ w_ybit}};
            MODE_SOLID:   tdata_d = solid_d;
            default:      tdata_d = '0;
        endcase
        tuser_d = (x_d == '0) && (y_d == '0);
        tlast_d = (x_d == X_LAST);
    end

    // ------------------------------------------------------------------------
    // Control FSM and beat registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            pos_q        <= '0;
            count_q      <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= w_frame_end;

            // Beat registers change only when a new beat is loaded, so an
            // unaccepted beat stays stable under backpressure.
            if (w_load) begin
                x_q      <= x_d;
                y_q      <= y_d;
                pos_q    <= pos_d;
                mode_q   <= mode_d;
                solid_q  <= solid_d;
                tvalid_q <= 1'b1;
                tdata_q  <= tdata_d;
                tuser_q  <= tuser_d;
                tlast_q  <= tlast_d;
                // count_q holds the value of the next COUNT beat; every
                // loaded beat is accepted before anything but reset intervenes.
                if (mode_d == MODE_COUNT) begin
                    count_q <= count_q + 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_frame_end && !enable) begin
                        state_q  <= S_IDLE;
                        tvalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix.pixel_tvalid = tvalid_q;
    assign pix.pixel_tdata  = tdata_q;
    assign pix.pixel_tuser  = tuser_q;
    assign pix.pixel_tlast  = tlast_q;
    assign frame_done       = frame_done_q;

endmodule : pattern_source
`default_nettype wire
